// File: rtl/track_result_buffer_pkg.sv
// Shared widths and packing helpers for the tracking-result buffer.
// Entry layout, MSB to LSB: {seq, i, q, wdf}.
package track_result_buffer_pkg;

    localparam int TRB_SEQ_W        = 8;
    localparam int TRB_ACC_W_DEF    = 18;
    localparam int TRB_WDF_W_DEF    = 24;
    localparam int TRB_DEPTH_LG_DEF = 3;
    localparam logic [TRB_SEQ_W-1:0] TRB_OVF_MAX = 8'd255;

    function automatic int trb_entry_w(input int acc_w, input int wdf_w);
        return TRB_SEQ_W + 2 * acc_w + wdf_w;
    endfunction

    function automatic int trb_q_lsb(input int wdf_w);
        return wdf_w;
    endfunction

    function automatic int trb_i_lsb(input int acc_w, input int wdf_w);
        return wdf_w + acc_w;
    endfunction

    function automatic int trb_seq_lsb(input int acc_w, input int wdf_w);
        return wdf_w + 2 * acc_w;
    endfunction

endpackage

// File: rtl/track_result_buffer_sync_fifo.sv
// Storage FIFO for the result buffer: wrap-around pointers plus an occupancy counter.
// A pop is honoured only when not empty; a push when full only together with a pop.
module track_result_buffer_sync_fifo #(
    parameter int WIDTH    = 68,
    parameter int DEPTH_LG = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]    head,
    output logic [DEPTH_LG:0]   level,
    output logic                full,
    output logic                empty
);

    localparam int                  DEPTH     = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0]   DEPTH_CNT = (DEPTH_LG+1)'(DEPTH);
    localparam logic [DEPTH_LG:0]   CNT_ONE   = (DEPTH_LG+1)'(1);
    localparam logic [DEPTH_LG-1:0] PTR_ONE   = DEPTH_LG'(1);

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LG-1:0] wr_ptr_r;
    logic [DEPTH_LG-1:0] rd_ptr_r;
    logic [DEPTH_LG:0]   count_r;
    logic                full_s;
    logic                empty_s;
    logic                do_push_s;
    logic                do_pop_s;

    // Status decode and qualified push/pop; flush overrides both.
    always_comb begin
        full_s    = (count_r == DEPTH_CNT);
        empty_s   = (count_r == {(DEPTH_LG+1){1'b0}});
        do_pop_s  = pop & ~empty_s & ~flush;
        do_push_s = push & ~flush & (~full_s | do_pop_s);
    end

    // Entry storage; left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {DEPTH_LG{1'b0}};
            rd_ptr_r <= {DEPTH_LG{1'b0}};
            count_r  <= {(DEPTH_LG+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {DEPTH_LG{1'b0}};
            rd_ptr_r <= {DEPTH_LG{1'b0}};
            count_r  <= {(DEPTH_LG+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign level = count_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/track_result_buffer.sv
// Captures per-epoch tracking results, tags them with a sequence number and queues
// them for the back-end reader; drops on a full queue are counted, not silent.
module track_result_buffer
    import track_result_buffer_pkg::*;
#(
    parameter int ACC_W    = TRB_ACC_W_DEF,
    parameter int WDF_W    = TRB_WDF_W_DEF,
    parameter int DEPTH_LG = TRB_DEPTH_LG_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tracking_ready,
    input  logic [ACC_W-1:0]      i_prompt_k,
    input  logic [ACC_W-1:0]      q_prompt_k,
    input  logic [WDF_W-1:0]      w_df_k,
    input  logic                  flush,
    input  logic                  clear_overflow,
    output logic                  rd_valid,
    output logic [TRB_SEQ_W-1:0]  rd_seq,
    output logic [ACC_W-1:0]      rd_i,
    output logic [ACC_W-1:0]      rd_q,
    output logic [WDF_W-1:0]      rd_wdf,
    input  logic                  rd_ack,
    output logic [DEPTH_LG:0]     level,
    output logic                  overflow,
    output logic [TRB_SEQ_W-1:0]  ovf_count
);

    localparam int ENTRY_W = trb_entry_w(ACC_W, WDF_W);
    localparam int I_LSB   = trb_i_lsb(ACC_W, WDF_W);
    localparam int Q_LSB   = trb_q_lsb(WDF_W);
    localparam int SEQ_LSB = trb_seq_lsb(ACC_W, WDF_W);

    logic [TRB_SEQ_W-1:0] seq_r;
    logic                 overflow_r;
    logic [TRB_SEQ_W-1:0] ovf_count_r;
    logic [ENTRY_W-1:0]   entry_s;
    logic [ENTRY_W-1:0]   head_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 valid_s;
    logic                 drop_s;

    assign entry_s = {seq_r, i_prompt_k, q_prompt_k, w_df_k};
    // A same-cycle ack on a full queue makes room, so only an un-acked full write drops.
    assign drop_s  = tracking_ready & ~flush & full_s & ~rd_ack;
    assign valid_s = ~empty_s;

    track_result_buffer_sync_fifo #(
        .WIDTH    (ENTRY_W),
        .DEPTH_LG (DEPTH_LG)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tracking_ready),
        .pop     (rd_ack),
        .flush   (flush),
        .data_in (entry_s),
        .head    (head_s),
        .level   (level),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Sequence tag advances on every pulse, stored, dropped or flushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_r <= 8'd0;
        end else if (tracking_ready) begin
            seq_r <= seq_r + 8'd1;
        end else begin
            seq_r <= seq_r;
        end
    end

    // Sticky overflow and saturating drop count; a drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            ovf_count_r <= 8'd0;
        end else if (clear_overflow) begin
            overflow_r  <= drop_s;
            ovf_count_r <= drop_s ? 8'd1 : 8'd0;
        end else if (drop_s) begin
            overflow_r  <= 1'b1;
            ovf_count_r <= (ovf_count_r == TRB_OVF_MAX) ? ovf_count_r : ovf_count_r + 8'd1;
        end else begin
            overflow_r  <= overflow_r;
            ovf_count_r <= ovf_count_r;
        end
    end

    assign rd_valid  = valid_s;
    assign rd_seq    = head_s[SEQ_LSB +: TRB_SEQ_W] & {TRB_SEQ_W{valid_s}};
    assign rd_i      = head_s[I_LSB +: ACC_W] & {ACC_W{valid_s}};
    assign rd_q      = head_s[Q_LSB +: ACC_W] & {ACC_W{valid_s}};
    assign rd_wdf    = head_s[0 +: WDF_W] & {WDF_W{valid_s}};
    assign overflow  = overflow_r;
    assign ovf_count = ovf_count_r;

endmodule
